shift_req_queue: RTL and testbench
==================================

# shift_req_queue

Request-buffering front end for the 32-bit right-shift unit. It accepts shift requests (operand, shift amount, logical/arithmetic select) over a valid/ready handshake and holds them in a small FIFO. The FIFO head drives the combinational right shifter. The shifter's selected result is captured into a registered output stage with its own valid/ready handshake. The block sits between the ALU operand path and the shifter, and registers what the shifter produces for downstream consumers.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  queue can accept; equals (count != DEPTH).
- in_src0  input  32  operand to shift.
- in_src1  input  5  shift amount, 0..31.
- in_arith  input  1  1 = arithmetic right shift, 0 = logical right shift.
- sh_src0  output  32  FIFO-head operand to shifter; 0 when empty.
- sh_src1  output  5  FIFO-head shift amount to shifter; 0 when empty.
- sh_res_l  input  32  shifter logical result (combinational from sh_*).
- sh_res_a  input  32  shifter arithmetic result.
- out_valid  output  1  out_data holds an unconsumed result.
- out_ready  input  1  consumer takes result.
- out_data  output  32  registered shift result.
- count  output  clog2(DEPTH)+1  FIFO occupancy; excludes the output register.

## Operation
- FIFO storage: each entry is {src0[31:0], src1[4:0], arith}. Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count tracks occupancy.
- Push: occurs when in_valid && in_ready. The entry is written at the write pointer, and the write pointer increments.
- Head: when count != 0, sh_src0 and sh_src1 come from the entry at the read pointer.
- Pop/capture:
  - Condition: (count != 0) && (!out_valid || out_ready).
  - On capture, out_data <= head.arith ? sh_res_a : sh_res_l.
  - out_valid <= 1, and the read pointer increments.
- Consume without refill: if out_valid && out_ready and no capture occurs this cycle, out_valid <= 0. out_data holds its last value.
- Same-cycle push and pop: count is unchanged. The entry pushed this cycle is not visible at the head until the next cycle, so an entry is never pushed and popped in the same cycle.
- Full: in_ready = 0 whenever count == DEPTH, even if a pop occurs that cycle. There is no push-on-pop when full.
- Empty: no capture takes place. sh_src0 and sh_src1 are forced to 0.
- Ordering: results leave the block strictly in request order.
- in_src1 is used unmodified; there is no range check, since all 32 values are legal.

## Timing
- Reset values: out_valid = 0, out_data = 0, count = 0, both pointers = 0, in_ready = 1 (when rst = 0). sh_src0 and sh_src1 are 0 because the FIFO is empty.
- Reset mid-operation: all queued entries and the output result are discarded on that edge. No out_valid pulse follows.
- Latency:
  - A request accepted at edge N into an empty queue, with the output register free, gives out_valid = 1 after edge N+1.
  - Throughput is 1 result per cycle while out_ready stays high.
- Back-pressure:
  - With out_ready held 0, DEPTH+1 requests are accepted in total: one in the output register and DEPTH in the FIFO.
  - in_ready then drops.
- in_ready depends only on registered count, with no combinational path from out_ready.
- out_valid and out_data are registered outputs.

## Configuration
- SHIFT_STATS_EN:
  - Defined: adds output port done_cnt [15:0]. It increments on every out_valid && out_ready, saturates at 0xFFFF, and is reset to 0 by rst.
  - Undefined: the port and its counter are absent, and all other behaviour is identical.

## Test plan
- Basic operation, both shift types:
  - Reset, then push src0 = 0x80000000, src1 = 4, arith = 1 with out_ready = 1 -> out_data = 0xF8000000 one cycle after accept.
  - Same operand with arith = 0 -> 0x08000000.
- Back-pressure: hold out_ready = 0 and offer 8 back-to-back requests -> exactly 5 accepted, count = 4, in_ready = 0. Raise out_ready -> 5 results in order, 1 per cycle.
- Streaming: sustained in_valid and out_ready with src1 = 0..31 on src0 = 0xF0F0F0F0, arith = 1 -> 32 consecutive results. The last is 0xFFFFFFFF, and there are no bubbles after the first.
- Pointer wrap: interleave pushes and pops over 3×DEPTH requests -> no loss or reorder.
- Same-cycle push/pop: push and pop together at count = 2 -> count stays 2.
- Reset mid-operation: assert rst with count = 3 and out_valid = 1 -> next cycle count = 0, out_valid = 0, out_data = 0, in_ready = 1. With SHIFT_STATS_EN, done_cnt = 0.

Source files
------------

// File: rtl/shift_req_queue.sv
// shift_req_queue: request FIFO in front of the 32-bit right shifter, with a
// registered result stage carrying its own valid/ready handshake.
// The FIFO head feeds the external combinational shifter; the selected
// logical/arithmetic result is captured into out_data when the output stage
// is free or being drained in the same cycle.
// Optional feature macro: SHIFT_STATS_EN adds the done_cnt[15:0] port, a
// saturating count of results handed to the consumer.

module shift_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    // request side
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_src0,
    input  logic [4:0]                 in_src1,
    input  logic                       in_arith,
    // shifter side
    output logic [31:0]                sh_src0,
    output logic [4:0]                 sh_src1,
    input  logic [31:0]                sh_res_l,
    input  logic [31:0]                sh_res_a,
    // result side
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic [$clog2(DEPTH):0]     count
`ifdef SHIFT_STATS_EN
    ,
    output logic [15:0]                done_cnt
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + 5 + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q,  out_data_d;

    // handshake decodes
    logic             not_empty;
    logic             push;
    logic             pop;

    // entry being written and the entry at the head
    logic [ENTRY_W-1:0]              wr_entry;
    logic [DEPTH-1:0][ENTRY_W-1:0]   entry_arr;
    logic [ENTRY_W-1:0]              head_entry;
    logic [31:0]                     head_src0;
    logic [4:0]                      head_src1;
    logic                            head_arith;

    // ------------------------------------------------------------------
    // FIFO storage: one register per slot, written only when the write
    // pointer selects it. Contents need no reset; an empty FIFO never
    // exposes them because the head outputs are gated by occupancy.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic               wr_en;
            logic [ENTRY_W-1:0] data_q;
            logic [ENTRY_W-1:0] data_d;

            // select this slot when a push targets it
            always_comb begin
                wr_en  = push && (wr_ptr_q == PTR_W'(gi));
                data_d = wr_en ? wr_entry : data_q;
            end

            // slot register
            always_ff @(posedge clk) begin
                data_q <= data_d;
            end

            assign entry_arr[gi] = data_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshakes, head decode and next-state computation
    // ------------------------------------------------------------------
    // in_ready looks only at the registered count so there is no
    // combinational path from out_ready; a full queue never accepts even
    // if it is popping in the same cycle.
    always_comb begin
        wr_entry   = {in_src0, in_src1, in_arith};

        not_empty  = (count_q != '0);
        in_ready   = (count_q != FULL_CNT);
        push       = in_valid && in_ready;
        // the entry pushed this cycle is not the head yet, so pop depends
        // only on registered occupancy
        pop        = not_empty && (!out_valid_q || out_ready);

        head_entry = entry_arr[rd_ptr_q];
        head_src0  = head_entry[ENTRY_W-1 -: 32];
        head_src1  = head_entry[5:1];
        head_arith = head_entry[0];

        sh_src0    = not_empty ? head_src0 : 32'd0;
        sh_src1    = not_empty ? head_src1 : 5'd0;

        wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = head_arith ? sh_res_a : sh_res_l;
        end else if (out_ready) begin
            // consumed with nothing to refill; data is left as is
            out_valid_d = 1'b0;
        end
    end

    // control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'd0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

`ifdef SHIFT_STATS_EN
    // ------------------------------------------------------------------
    // Completed-result counter, saturating at all ones
    // ------------------------------------------------------------------
    logic [15:0] done_cnt_q, done_cnt_d;

    // count each result taken by the consumer
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (out_valid_q && out_ready && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt_q <= 16'd0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_shift_req_queue.sv
// tb_shift_req_queue: directed vector table, hand sequences and random
// traffic against a queue-based reference model of shift_req_queue.

module tb_shift_req_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_src0;
    logic [4:0]  in_src1;
    logic        in_arith;
    logic [31:0] sh_src0;
    logic [4:0]  sh_src1;
    logic [31:0] sh_res_l;
    logic [31:0] sh_res_a;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  count;
`ifdef SHIFT_STATS_EN
    logic [15:0] done_cnt;
`endif

    always #5 clk = ~clk;

    // external combinational shifter
    assign sh_res_l = sh_src0 >> sh_src1;
    assign sh_res_a = $unsigned($signed(sh_src0) >>> sh_src1);

    shift_req_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_src0  (in_src0),
        .in_src1  (in_src1),
        .in_arith (in_arith),
        .sh_src0  (sh_src0),
        .sh_src1  (sh_src1),
        .sh_res_l (sh_res_l),
        .sh_res_a (sh_res_a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
`ifdef SHIFT_STATS_EN
        ,
        .done_cnt (done_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // reference result from the shift definition: logical shift, then fill
    // the vacated upper bits with the sign for arithmetic requests
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] s,
                                              input logic ar);
        logic [31:0] r;
        logic [31:0] ones;
        ones = 32'hFFFFFFFF;
        r = v >> s;
        if (ar && v[31]) r = r | ~(ones >> s);
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] s0;
        logic [4:0]  s1;
        logic        ar;
    } req_t;

    req_t        mfifo[$];
    logic        m_ov = 1'b0;
    logic [31:0] m_od = 32'd0;
    int          m_done = 0;

    // apply one cycle of inputs, advance the model, then compare after the edge
    task automatic cycle(input logic rst_i, input logic iv, input logic [31:0] s0,
                         input logic [4:0] s1, input logic ar, input logic ordy);
        logic pre_rdy;
        logic do_push;
        req_t r;
        rst       = rst_i;
        in_valid  = iv;
        in_src0   = s0;
        in_src1   = s1;
        in_arith  = ar;
        out_ready = ordy;

        pre_rdy = (mfifo.size() != DEPTH);
        if (rst_i) begin
            mfifo.delete();
            m_ov   = 1'b0;
            m_od   = 32'd0;
            m_done = 0;
        end else begin
            do_push = iv && pre_rdy;
            if (m_ov && ordy && m_done < 65535) m_done++;
            if (mfifo.size() != 0 && (!m_ov || ordy)) begin
                r    = mfifo.pop_front();
                m_od = ref_shift(r.s0, r.s1, r.ar);
                m_ov = 1'b1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (do_push) begin
                r.s0 = s0;
                r.s1 = s1;
                r.ar = ar;
                mfifo.push_back(r);
            end
        end

        @(posedge clk);
        #1;
        check("m_out_valid", 32'(out_valid), 32'(m_ov));
        check("m_out_data",  out_data, m_od);
        check("m_count",     32'(count), 32'(mfifo.size()));
        check("m_in_ready",  32'(in_ready), 32'(mfifo.size() != DEPTH));
        check("m_sh_src0",   sh_src0, (mfifo.size() != 0) ? mfifo[0].s0 : 32'd0);
        check("m_sh_src1",   32'(sh_src1), (mfifo.size() != 0) ? 32'(mfifo[0].s1) : 32'd0);
`ifdef SHIFT_STATS_EN
        check("m_done_cnt",  32'(done_cnt), 32'(m_done));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] s0;
        logic [4:0]  s1;
        logic        ar;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_cnt;
        logic        e_rdy;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic r, input logic iv, input logic [31:0] s0,
                                input logic [4:0] s1, input logic ar, input logic ordy,
                                input logic e_ov, input logic [31:0] e_od,
                                input logic [2:0] e_cnt, input logic e_rdy);
        vec_t v;
        v.rst = r; v.iv = iv; v.s0 = s0; v.s1 = s1; v.ar = ar; v.ordy = ordy;
        v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt; v.e_rdy = e_rdy;
        vt.push_back(v);
    endfunction

    initial begin
        int          n_res;
        logic        started;
        logic        bubble;
        logic [31:0] last;

        rst = 1'b1; in_valid = 1'b0; in_src0 = '0; in_src1 = '0;
        in_arith = 1'b0; out_ready = 1'b0;

        //   rst iv  src0          s1 ar ordy | ov  out_data      cnt rdy
        // reset and basic arithmetic / logical shift
        add(1, 0, 32'h0,        0, 0, 0,   0, 32'h0,        0, 1);
        add(0, 1, 32'h80000000, 4, 1, 1,   0, 32'h0,        1, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'hF8000000, 0, 1);
        add(0, 1, 32'h80000000, 4, 0, 1,   0, 32'hF8000000, 1, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'h08000000, 0, 1);
        add(0, 0, 32'h0,        0, 0, 1,   0, 32'h08000000, 0, 1);
        // back-pressure: 8 offers, 5 accepted
        add(0, 1, 32'h100,      0, 0, 0,   0, 32'h08000000, 1, 1);
        add(0, 1, 32'h101,      1, 0, 0,   1, 32'h100,      1, 1);
        add(0, 1, 32'h102,      2, 0, 0,   1, 32'h100,      2, 1);
        add(0, 1, 32'h103,      3, 0, 0,   1, 32'h100,      3, 1);
        add(0, 1, 32'h104,      4, 0, 0,   1, 32'h100,      4, 0);
        add(0, 1, 32'h105,      5, 0, 0,   1, 32'h100,      4, 0);
        add(0, 1, 32'h106,      6, 0, 0,   1, 32'h100,      4, 0);
        add(0, 1, 32'h107,      7, 0, 0,   1, 32'h100,      4, 0);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'h80,       3, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'h40,       2, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'h20,       1, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'h10,       0, 1);
        add(0, 0, 32'h0,        0, 0, 1,   0, 32'h10,       0, 1);
        // same-cycle push and pop at count 2
        add(0, 1, 32'hAAAA0000, 16, 1, 0,  0, 32'h10,       1, 1);
        add(0, 1, 32'h12345678, 8, 1, 0,   1, 32'hFFFFAAAA, 1, 1);
        add(0, 1, 32'h80000001, 31, 0, 0,  1, 32'hFFFFAAAA, 2, 1);
        add(0, 1, 32'hFFFFFFFF, 0, 0, 1,   1, 32'h00123456, 2, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'h1,        1, 1);
        add(0, 0, 32'h0,        0, 0, 1,   1, 32'hFFFFFFFF, 0, 1);
        add(0, 0, 32'h0,        0, 0, 1,   0, 32'hFFFFFFFF, 0, 1);
        // reset with count 3 and a pending result
        add(0, 1, 32'h11111111, 1, 0, 0,   0, 32'hFFFFFFFF, 1, 1);
        add(0, 1, 32'h22222222, 1, 0, 0,   1, 32'h08888888, 1, 1);
        add(0, 1, 32'h33333333, 1, 0, 0,   1, 32'h08888888, 2, 1);
        add(0, 1, 32'h44444444, 1, 0, 0,   1, 32'h08888888, 3, 1);
        add(1, 1, 32'h55555555, 1, 0, 1,   0, 32'h0,        0, 1);
        add(0, 0, 32'h0,        0, 0, 1,   0, 32'h0,        0, 1);

        for (int i = 0; i < vt.size(); i++) begin
            cycle(vt[i].rst, vt[i].iv, vt[i].s0, vt[i].s1, vt[i].ar, vt[i].ordy);
            check("vec_out_valid", 32'(out_valid), 32'(vt[i].e_ov));
            check("vec_out_data",  out_data, vt[i].e_od);
            check("vec_count",     32'(count), 32'(vt[i].e_cnt));
            check("vec_in_ready",  32'(in_ready), 32'(vt[i].e_rdy));
            $display("vec %0d: rst=%0b in_valid=%0b out_ready=%0b -> out_valid=%0b out_data=0x%08h count=%0d in_ready=%0b",
                     i, vt[i].rst, vt[i].iv, vt[i].ordy, out_valid, out_data, count, in_ready);
        end

        // streaming: 32 back-to-back arithmetic shifts, no bubbles
        n_res = 0; started = 1'b0; bubble = 1'b0; last = 32'd0;
        for (int k = 0; k < 36; k++) begin
            if (k < 32) cycle(1'b0, 1'b1, 32'hF0F0F0F0, 5'(k), 1'b1, 1'b1);
            else        cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
            if (out_valid) begin
                if (n_res < 32) check("stream_data", out_data, ref_shift(32'hF0F0F0F0, 5'(n_res), 1'b1));
                $display("stream result %0d: 0x%08h", n_res, out_data);
                last = out_data;
                n_res++;
                started = 1'b1;
            end else if (started && n_res < 32) begin
                bubble = 1'b1;
            end
        end
        check("stream_count",  32'(n_res), 32'd32);
        check("stream_bubble", 32'(bubble), 32'd0);
        check("stream_last",   last, 32'hFFFFFFFF);

        // random traffic with varying back-pressure and occasional reset
        for (int j = 0; j < 600; j++) begin
            logic r;
            logic ordy;
            r = (j > 300) && ($urandom_range(0, 79) == 0);
            if (((j / 100) % 2) == 1) ordy = ($urandom_range(0, 3) == 0);
            else                      ordy = ($urandom_range(0, 3) != 0);
            cycle(r, ($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), ordy);
        end
        for (int j = 0; j < 2 * DEPTH + 2; j++) begin
            cycle(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
        end
        check("drain_count",     32'(count), 32'd0);
        check("drain_out_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
